// File: rtl/fft_pkg.sv
// fft_pkg: FFT sizing constants and loader FSM state, shared
// by the AGU and the sample loader.
package fft_pkg;

  localparam int BIT_WIDTH = 16;
  localparam int LEVEL     = 9;
  localparam int N         = 2 ** LEVEL;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_HOLD,
    ST_CLEAR
  } fft_state_t;

endpackage

// File: rtl/fft_loader_if.sv
// fft_loader_if: sample stream, RAM0 write port, AGU control and
// result handshake between the loader (master) and its neighbours.
interface fft_loader_if #(
  parameter int BIT_WIDTH = fft_pkg::BIT_WIDTH,
  parameter int LEVEL     = fft_pkg::LEVEL
);

  logic signed [BIT_WIDTH-1:0] sample_in;
  logic                        sample_valid;
  logic                        sample_ready;
  logic [LEVEL-1:0]            load_addr;
  logic [2*BIT_WIDTH-1:0]      load_data;
  logic                        load_we;
  logic                        fft_load;
  logic                        fft_enable;
  logic                        fft_done;
  logic                        agu_reset;
  logic                        result_valid;
  logic                        result_ack;

  modport master (
    input  sample_in,
    input  sample_valid,
    output sample_ready,
    output load_addr,
    output load_data,
    output load_we,
    output fft_load,
    output fft_enable,
    input  fft_done,
    output agu_reset,
    output result_valid,
    input  result_ack
  );

  modport slave (
    output sample_in,
    output sample_valid,
    input  sample_ready,
    input  load_addr,
    input  load_data,
    input  load_we,
    input  fft_load,
    input  fft_enable,
    output fft_done,
    input  agu_reset,
    input  result_valid,
    output result_ack
  );

endinterface

// File: rtl/bitrev.sv
// bitrev: combinational LEVEL-bit index reversal.
// idx_i in, rev_o = idx_i with bit order reversed.
module bitrev #(
  parameter int LEVEL = fft_pkg::LEVEL
) (
  input  logic [LEVEL-1:0] idx_i,
  output logic [LEVEL-1:0] rev_o
);

  for (genvar i = 0; i < LEVEL; i++) begin : g_bit
    assign rev_o[i] = idx_i[LEVEL-1-i];
  end

endmodule

// File: rtl/fft_loader.sv
// fft_loader: writes N real samples into RAM0 in bit-reversed order,
// runs the AGU, holds the result until acked. Ports: clk, reset, bus.
module fft_loader #(
  parameter int BIT_WIDTH = fft_pkg::BIT_WIDTH,
  parameter int LEVEL     = fft_pkg::LEVEL
) (
  input  logic         clk,
  input  logic         reset,
  fft_loader_if.master bus
);

  import fft_pkg::*;

  localparam int unsigned FRAME = 2 ** LEVEL;
  localparam logic [LEVEL:0] K_LAST = (LEVEL+1)'(FRAME - 1);

  fft_state_t state_q, state_d;

  logic [LEVEL:0]         k_q, k_d;
  logic                   accept;
  logic [LEVEL-1:0]       rev_addr;

  logic                   we_q, we_d;
  logic [LEVEL-1:0]       addr_q, addr_d;
  logic [2*BIT_WIDTH-1:0] data_q, data_d;
  logic                   load_q, load_d;
  logic                   en_q, en_d;
  logic                   rv_q, rv_d;

  assign accept = bus.sample_valid & (state_q == ST_LOAD);

  bitrev #(.LEVEL(LEVEL)) u_bitrev (
    .idx_i (k_q[LEVEL-1:0]),
    .rev_o (rev_addr)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      k_q     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      load_q  <= 1'b1;
      en_q    <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      load_q  <= load_d;
      en_q    <= en_d;
      rv_q    <= rv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      ST_LOAD: begin
        if (accept) begin
          k_d = k_q + (LEVEL+1)'(1);
          if (k_q == K_LAST) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.fft_done) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.result_ack) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        k_d     = '0;
        state_d = ST_LOAD;
      end
      default: begin
        k_d     = '0;
        state_d = ST_LOAD;
      end
    endcase
  end

  // Registered outputs are computed from the next state so they
  // line up with the state they describe.
  always_comb begin
    we_d   = accept;
    addr_d = accept ? rev_addr : addr_q;
    data_d = accept ? {bus.sample_in, {BIT_WIDTH{1'b0}}} : data_q;
    load_d = (state_d == ST_LOAD);
    en_d   = (state_d == ST_RUN);
    rv_d   = (state_d == ST_HOLD);
  end

  assign bus.sample_ready = (state_q == ST_LOAD);
  assign bus.agu_reset    = reset & (state_q != ST_CLEAR);
  assign bus.load_we      = we_q;
  assign bus.load_addr    = addr_q;
  assign bus.load_data    = data_q;
  assign bus.fft_load     = load_q;
  assign bus.fft_enable   = en_q;
  assign bus.result_valid = rv_q;

endmodule

// File: tb/tb_fft_loader.sv
// tb_fft_loader: frame-level reference model plus directed and
// randomized frames for fft_loader.
module tb_fft_loader;

  localparam int BW = 16;
  localparam int LV = 9;
  localparam int NS = 512;

  typedef enum int {P_LOAD, P_RUN, P_HOLD, P_CLEAR} phase_e;

  typedef struct {
    int          idx;
    int          addr;
    logic [31:0] data;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fft_loader_if #(.BIT_WIDTH(BW), .LEVEL(LV)) ifc ();

  fft_loader #(.BIT_WIDTH(BW), .LEVEL(LV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int dut_log[$];
  logic [31:0] dut_dlog[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rev9(input int k);
    int r = 0;
    for (int i = 0; i < LV; i++)
      if (((k >> i) & 1) == 1) r = r | (1 << (LV - 1 - i));
    return r;
  endfunction

  function automatic int log_at(input int i);
    if (i < dut_log.size()) return dut_log[i];
    return -1;
  endfunction

  // Reference: frame-level behaviour from the sample count and phase.
  phase_e      m_ph;
  int          m_cnt;
  bit          m_we;
  int          m_addr;
  logic [31:0] m_data;

  always @(posedge clk) begin
    m_we <= 1'b0;
    if (!reset) begin
      m_ph  <= P_LOAD;
      m_cnt <= 0;
    end else begin
      case (m_ph)
        P_LOAD: if (ifc.sample_valid) begin
          m_we   <= 1'b1;
          m_addr <= rev9(m_cnt);
          m_data <= {ifc.sample_in, 16'h0000};
          m_cnt  <= m_cnt + 1;
          if (m_cnt == NS - 1) m_ph <= P_RUN;
        end
        P_RUN:  if (ifc.fft_done) m_ph <= P_HOLD;
        P_HOLD: if (ifc.result_ack) m_ph <= P_CLEAR;
        default: begin
          m_ph  <= P_LOAD;
          m_cnt <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (ifc.load_we === 1'b1) begin
      dut_log.push_back(int'(ifc.load_addr));
      dut_dlog.push_back(ifc.load_data);
    end
    if (chk_en) begin
      chk("sample_ready", ifc.sample_ready, m_ph == P_LOAD);
      chk("fft_load", ifc.fft_load, m_ph == P_LOAD);
      chk("fft_enable", ifc.fft_enable, m_ph == P_RUN);
      chk("result_valid", ifc.result_valid, m_ph == P_HOLD);
      chk("agu_reset", ifc.agu_reset, reset && (m_ph != P_CLEAR));
      chk("load_we", ifc.load_we, m_we);
      if (m_we) begin
        chk("load_addr", ifc.load_addr, m_addr);
        chk("load_data", ifc.load_data, m_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: valid held, data=k; 1: valid toggles, random data, noise;
  // 2: random valid, random data, noise on ack/done.
  task automatic send(input int n, input int mode, input int base);
    int sent = 0;
    int cyc = 0;
    bit v;
    while (sent < n && cyc < 4 * n + 20) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = $urandom_range(0, 3) != 0;
      endcase
      ifc.sample_valid = v;
      ifc.sample_in = (mode == 0) ? 16'(base + sent) : 16'($urandom);
      if (mode != 0) begin
        ifc.result_ack = 1'($urandom_range(0, 1));
        ifc.fft_done   = 1'($urandom_range(0, 1));
      end
      if (v && ifc.sample_ready) sent++;
      step();
      cyc++;
    end
    ifc.sample_valid = 1'b0;
    ifc.result_ack   = 1'b0;
    ifc.fft_done     = 1'b0;
    chk("send_accepts", sent, n);
  endtask

  task automatic close_frame(input int run_cycles);
    repeat (run_cycles) step();
    ifc.fft_done = 1'b1;
    step();
    ifc.fft_done = 1'b0;
    chk("close_en_off", ifc.fft_enable, 0);
    chk("close_rv_on", ifc.result_valid, 1);
    ifc.result_ack = 1'b1;
    step();
    ifc.result_ack = 1'b0;
    chk("close_clear_agu", ifc.agu_reset, 0);
    step();
    chk("close_load_ready", ifc.sample_ready, 1);
  endtask

  vec_t tbl[6];
  bit   seen[NS];
  int   dup;
  int   miss;

  initial begin
    tbl[0] = '{0,   0,   32'h0000_0000};
    tbl[1] = '{1,   256, 32'h0001_0000};
    tbl[2] = '{2,   128, 32'h0002_0000};
    tbl[3] = '{3,   384, 32'h0003_0000};
    tbl[4] = '{300, 105, 32'h012C_0000};
    tbl[5] = '{511, 511, 32'h01FF_0000};

    ifc.sample_in    = '0;
    ifc.sample_valid = 1'b0;
    ifc.fft_done     = 1'b0;
    ifc.result_ack   = 1'b0;
    reset = 1'b0;
    repeat (3) step();
    chk("rst_ready", ifc.sample_ready, 1);
    chk("rst_we", ifc.load_we, 0);
    chk("rst_addr", ifc.load_addr, 0);
    chk("rst_data", ifc.load_data, 0);
    chk("rst_en", ifc.fft_enable, 0);
    chk("rst_rv", ifc.result_valid, 0);
    chk("rst_agu", ifc.agu_reset, 0);
    reset = 1'b1;
    chk_en = 1'b1;
    step();

    // Frame 1: k=0..511, valid held high.
    dut_log.delete();
    dut_dlog.delete();
    send(NS, 0, 0);
    chk("f1_ready_low", ifc.sample_ready, 0);
    chk("f1_run", ifc.fft_enable, 1);
    step();
    chk("f1_writes", dut_log.size(), NS);
    for (int i = 0; i < 6; i++) begin
      chk("f1_tbl_addr", log_at(tbl[i].idx), tbl[i].addr);
      if (tbl[i].idx < dut_dlog.size())
        chk("f1_tbl_data", dut_dlog[tbl[i].idx], tbl[i].data);
    end

    // RUN: valid and ack asserted are ignored until done.
    ifc.sample_valid = 1'b1;
    for (int c = 0; c < 2302; c++) begin
      ifc.result_ack = (c < 100);
      step();
    end
    ifc.result_ack = 1'b0;
    ifc.fft_done = 1'b1;
    step();
    ifc.fft_done = 1'b0;
    chk("f1_done_en", ifc.fft_enable, 0);
    chk("f1_done_rv", ifc.result_valid, 1);
    for (int c = 0; c < 50; c++) begin
      ifc.fft_done = c[0];
      step();
    end
    ifc.fft_done = 1'b0;
    ifc.sample_valid = 1'b0;
    chk("f1_hold_rv", ifc.result_valid, 1);
    chk("f1_no_extra_wr", dut_log.size(), NS);
    ifc.result_ack = 1'b1;
    step();
    ifc.result_ack = 1'b0;
    chk("f1_clear_agu", ifc.agu_reset, 0);
    chk("f1_clear_rv", ifc.result_valid, 0);
    step();
    chk("f1_back_agu", ifc.agu_reset, 1);
    chk("f1_back_ready", ifc.sample_ready, 1);

    // Frame 2: toggling valid, ack/done noise during LOAD.
    dut_log.delete();
    dut_dlog.delete();
    send(NS, 1, 0);
    step();
    chk("f2_writes", dut_log.size(), NS);
    chk("f2_first_addr", log_at(0), 0);
    dup = 0;
    miss = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    foreach (dut_log[i]) begin
      if (dut_log[i] >= 0 && dut_log[i] < NS) begin
        if (seen[dut_log[i]]) dup++;
        seen[dut_log[i]] = 1'b1;
      end
    end
    foreach (seen[i]) if (!seen[i]) miss++;
    chk("f2_dups", dup, 0);
    chk("f2_gaps", miss, 0);
    close_frame(20);

    // Frame 3: reset after sample 300.
    dut_log.delete();
    dut_dlog.delete();
    send(301, 0, 0);
    reset = 1'b0;
    step();
    chk("f3_rst_agu", ifc.agu_reset, 0);
    chk("f3_rst_we", ifc.load_we, 0);
    chk("f3_rst_ready", ifc.sample_ready, 1);
    step();
    reset = 1'b1;
    dut_log.delete();
    send(1, 0, 77);
    step();
    chk("f3_restart_n", dut_log.size(), 1);
    chk("f3_restart_addr", log_at(0), 0);
    send(NS - 1, 2, 0);
    step();
    chk("f3_writes", dut_log.size(), NS);

    // Reset in RUN drops the frame; next frame starts at k=0.
    repeat (10) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("f4_rst_en", ifc.fft_enable, 0);
    chk("f4_rst_ready", ifc.sample_ready, 1);
    dut_log.delete();
    send(2, 0, 5);
    step();
    chk("f4_addr0", log_at(0), 0);
    chk("f4_addr1", log_at(1), 256);
    send(NS - 2, 2, 0);
    close_frame(5);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_loader.md
FFT_LOADER -- requirements
Module: fft_loader

Interface
REQ-001 Parameter BIT_WIDTH, default 16, real-sample width in bits.
REQ-002 Parameter LEVEL, default 9, log2 of FFT size; N = 2**LEVEL = 512.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; reset reset, synchronous, active-low; clock clk.
REQ-005 sample_in  input  BIT_WIDTH  signed real audio sample.
REQ-006 sample_valid  input  1  sample_in is valid this cycle.
REQ-007 sample_ready  output  1  loader accepts sample this cycle.
REQ-008 load_addr  output  LEVEL  data-RAM0 write address.
REQ-009 load_data  output  2*BIT_WIDTH  write word {real, imag}.
REQ-010 load_we  output  1  data-RAM0 write enable.
REQ-011 fft_load  output  1  high while loading; forces the AGU's read select.
REQ-012 fft_enable  output  1  run enable to the AGU.
REQ-013 fft_done  input  1  AGU reports all LEVEL stages complete.
REQ-014 agu_reset  output  1  active-low synchronous reset to the AGU.
REQ-015 result_valid  output  1  FFT result resident in RAM, held until acknowledged.
REQ-016 result_ack  input  1  downstream consumer has finished reading results.

Function
REQ-017 States: LOAD, RUN, HOLD, CLEAR; the FSM shall enter LOAD from reset.
REQ-018 LOAD: sample_ready=1, fft_load=1, fft_enable=0, agu_reset=1.
REQ-019 Accept = sample_valid & sample_ready; each accept increments a LEVEL+1-bit sample count k.
REQ-020 Write path registered, latency 1: the cycle after accepting sample k, load_we=1, load_addr=bitrev_LEVEL(k), load_data={sample_in, BIT_WIDTH'b0}.
REQ-021 load_we=0 in every cycle not immediately following an accept.
REQ-022 Accept of sample k=N-1 moves the FSM to RUN on the next edge; sample_ready drops that same edge, so exactly N samples are taken per frame.
REQ-023 RUN: fft_enable=1, fft_load=0, sample_ready=0; the final load write (REQ-020) lands in the first RUN cycle, and the AGU's first read occurs no earlier than the next cycle.
REQ-024 RUN with fft_done=1 -> HOLD; fft_enable=0 from HOLD entry.
REQ-025 HOLD: result_valid=1, sample_ready=0, fft_enable=0; the FSM remains in HOLD until result_ack=1.
REQ-026 HOLD with result_ack=1 -> CLEAR; result_valid drops on the same edge.
REQ-027 CLEAR lasts exactly one cycle: agu_reset=0, k cleared to 0, then -> LOAD.
REQ-028 result_ack outside HOLD shall be ignored; sample_valid outside LOAD shall be ignored, with no write and no count change.
REQ-029 fft_done outside RUN shall be ignored.
REQ-030 bitrev wraps within LEVEL bits: k=1 -> 256, k=2 -> 128, k=511 -> 511.

Reset
REQ-031 Reset low at an edge: FSM=LOAD, k=0, load_we=0, load_addr=0, load_data=0, fft_enable=0, result_valid=0.
REQ-032 While reset is low, agu_reset=0, so the AGU clears with the loader.
REQ-033 Reset mid-LOAD or mid-RUN discards the partial frame; the next frame restarts at k=0.

Structure
REQ-034 BIT_WIDTH, LEVEL, N and the FSM state enum shall live in shared package fft_pkg, used by both the AGU and the loader.
REQ-035 One sub-module, bitrev, shall be parameterised by LEVEL and purely combinational.
REQ-036 All outputs except sample_ready and agu_reset shall be registered.

Verification
REQ-037 Stream k=0..511 with sample value k, valid held high -> 512 writes, each at addr bitrev(k) with data {k,16'h0}; load_addr sequence starts 0,256,128,384; RUN entered; sample_ready=0 after the 512th accept.
REQ-038 Toggle sample_valid 1/0 each cycle -> still exactly 512 writes, with no gaps in the address sequence and no duplicate addresses.
REQ-039 In RUN, pulse fft_done at cycle 2304 -> fft_enable=0 next cycle; result_valid=1 and held for 50 cycles without result_ack; sample_valid=1 during HOLD is ignored.
REQ-040 Assert result_ack in HOLD -> exactly one cycle with agu_reset=0, then LOAD with sample_ready=1; second frame's first write lands at addr 0.
REQ-041 Drive reset low after sample 300 -> FSM=LOAD, load_we=0, agu_reset=0 while reset is low; the next accepted sample is written to addr 0.
REQ-042 Drive result_ack=1 and fft_done=1 during LOAD -> no state change; the loader keeps accepting samples.
